tinyalu_issuer: RTL and testbench

TINYALU_ISSUER -- requirements
Module: tinyalu_issuer

---
 rtl/tinyalu_pkg.sv | 47 ++++
 rtl/tinyalu_issuer_if.sv | 33 +++
 rtl/tinyalu_rsp_fifo.sv | 52 +++++
 rtl/tinyalu_issuer.sv | 129 ++++++++++++
 tb/tb_tinyalu_issuer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command issuer: operation encoding, op classes,
// issuer FSM states and the response record carried through the FIFO.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_ADD     = 3'b001,
        OP_AND     = 3'b010,
        OP_XOR     = 3'b011,
        OP_MUL     = 3'b100,
        OP_PULSE_A = 3'b101,
        OP_PULSE_B = 3'b110,
        OP_RST     = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        CLS_PULSE,
        CLS_WAIT,
        CLS_RESET
    } op_class_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_RST1,
        S_RST2
    } state_t;

    typedef struct packed {
        operation_t  op;
        logic [15:0] result;
        logic        err;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    // Only the four arithmetic ops wait for alu_done; 111 resets the ALU.
    function automatic op_class_t op_class(operation_t op);
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: return CLS_WAIT;
            OP_RST:                         return CLS_RESET;
            default:                        return CLS_PULSE;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_issuer_if.sv
// Command, ALU and response signals of the issuer. The issuer takes the slave
// view; the environment (command source, ALU, response sink) takes the master.
interface tinyalu_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_op;
    logic [15:0] rsp_result;
    logic        rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_start, alu_op, alu_a, alu_b, alu_reset_n,
               rsp_valid, rsp_op, rsp_result, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_start, alu_op, alu_a, alu_b, alu_reset_n,
               rsp_valid, rsp_op, rsp_result, rsp_err
    );
endinterface

// File: rtl/tinyalu_rsp_fifo.sv
// Synchronous FIFO holding completed ALU responses; DEPTH must be a power of
// two so the pointers wrap by plain overflow.
module tinyalu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage has no reset; the reset pointers and count make stale data unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/tinyalu_issuer.sv
// Accepts ALU commands, sequences start/done or reset pulses on the ALU side,
// and queues arithmetic results (or timeouts) for the consumer.
module tinyalu_issuer
    import tinyalu_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input logic              clk,
    input logic              reset_n,
    tinyalu_issuer_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic             alu_start_q;
    logic             alu_reset_n_q;
    operation_t       alu_op_q;
    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timed_out;
    logic             push;
    logic             accept;
    logic             fifo_empty;
    logic             fifo_full;
    rsp_t             push_rsp;
    rsp_t             head_rsp;

    // alu_reset_n_q is low only in reset and the RST states, so it also gates readiness.
    assign bus.cmd_ready = (state_q == S_IDLE) && alu_reset_n_q && !fifo_full;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        cnt_d           = cnt_q + 1'b1;
        timed_out       = (cnt_d == CNT_W'(TIMEOUT));
        push            = (state_q == S_WAIT) && alu_start_q && (bus.alu_done || timed_out);
        push_rsp.op     = alu_op_q;
        push_rsp.result = bus.alu_done ? bus.alu_result : 16'h0000;
        push_rsp.err    = !bus.alu_done;
    end

    // NOTE: registered state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            alu_start_q   <= 1'b0;
            alu_reset_n_q <= 1'b0;
            alu_op_q      <= OP_NOP;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            cnt_q         <= '0;
        end else begin
            alu_reset_n_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        alu_op_q <= operation_t'(bus.cmd_op);
                        alu_a_q  <= bus.cmd_a;
                        alu_b_q  <= bus.cmd_b;
                        cnt_q    <= '0;
                        case (op_class(operation_t'(bus.cmd_op)))
                            CLS_PULSE: begin
                                state_q     <= S_PULSE;
                                alu_start_q <= 1'b1;
                            end
                            CLS_WAIT:  state_q <= S_WAIT;
                            CLS_RESET: begin
                                state_q       <= S_RST1;
                                alu_reset_n_q <= 1'b0;
                            end
                            default:   state_q <= S_IDLE;
                        endcase
                    end
                end
                S_PULSE: begin
                    state_q     <= S_IDLE;
                    alu_start_q <= 1'b0;
                end
                S_WAIT: begin
                    if (!alu_start_q) begin
                        alu_start_q <= 1'b1;
                    end else if (push) begin
                        alu_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RST1: begin
                    alu_reset_n_q <= 1'b0;
                    state_q       <= S_RST2;
                end
                S_RST2: state_q <= S_IDLE;
                default: begin
                    state_q     <= S_IDLE;
                    alu_start_q <= 1'b0;
                end
            endcase
        end
    end

    tinyalu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (push_rsp),
        .pop_i   (bus.rsp_ready),
        .rdata_o (head_rsp),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.alu_start   = alu_start_q;
    assign bus.alu_reset_n = alu_reset_n_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.rsp_valid   = !fifo_empty;
    assign bus.rsp_op      = head_rsp.op;
    assign bus.rsp_result  = head_rsp.result;
    assign bus.rsp_err     = head_rsp.err;
endmodule

// File: tb/tb_tinyalu_issuer.sv
// Self-checking bench for tinyalu_issuer: directed scenarios plus a randomized
// run scored against a queue of expected responses.
module tb_tinyalu_issuer;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    tinyalu_issuer_if bus ();

    tinyalu_issuer #(
        .RSP_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] result;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   alu_lat    = 3;
    bit   alu_en     = 1'b1;
    bit   done_force = 1'b0;
    int   hi_cnt     = 0;

    function automatic logic [15:0] golden(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return 16'(a & b);
            3'd3:    return 16'(a ^ b);
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit is_wait(logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // ALU model: raises done during the alu_lat-th cycle that alu_start is high.
    initial begin
        bus.alu_done   = 1'b0;
        bus.alu_result = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            hi_cnt         = (bus.alu_start === 1'b1) ? hi_cnt + 1 : 0;
            bus.alu_done   = done_force || (alu_en && (bus.alu_start === 1'b1) && (hi_cnt == alu_lat));
            bus.alu_result = golden(bus.alu_op, bus.alu_a, bus.alu_b);
        end
    end

    // Response scoreboard: every pop is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            exp_t got;
            exp_t want;
            got    = {bus.rsp_op, bus.rsp_result, bus.rsp_err};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL rsp_unexpected: got %h, none expected", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures = failures + 1;
                    $display("FAIL rsp_data: got op=%0d res=%h err=%b, want op=%0d res=%h err=%b",
                             got.op, got.result, got.err, want.op, want.result, want.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        ok            = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i > 4) bus.rsp_ready = 1'b1;
            tick();
        end
        if (ok) tick();
        bus.cmd_valid = 1'b0;
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL cmd_accept: op=%0d not accepted within 100 cycles", op);
        end
    endtask

    task automatic count_start(output int hi);
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.alu_start === 1'b1) hi++;
            else if (hi > 0) break;
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.rsp_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) tick();
        checks = checks + 1;
        if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_reset_n, bus.rsp_valid, bus.cmd_ready} !== 23'h0) begin
            failures = failures + 1;
            $display("FAIL reset_state: start=%b op=%0d a=%h b=%h alu_rst_n=%b rsp_valid=%b cmd_ready=%b, want all 0",
                     bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_reset_n, bus.rsp_valid, bus.cmd_ready);
        end
        reset_n = 1'b1;
        tick();
        checks = checks + 1;
        if ({bus.alu_reset_n, bus.cmd_ready} !== 2'b11) begin
            failures = failures + 1;
            $display("FAIL reset_release: alu_rst_n=%b cmd_ready=%b, want 1 1", bus.alu_reset_n, bus.cmd_ready);
        end
    endtask

    task automatic test_add();
        bit ok;
        int hi;
        send_cmd(3'd1, 8'hFF, 8'h01, ok);
        alu_lat = 3;
        checks = checks + 1;
        if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b0, 3'd1, 8'hFF, 8'h01}) begin
            failures = failures + 1;
            $display("FAIL add_regs: start=%b op=%0d a=%h b=%h, want 0 1 ff 01",
                     bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        count_start(hi);
        checks = checks + 1;
        if (hi != 3) begin
            failures = failures + 1;
            $display("FAIL add_start_len: got %0d cycles, want 3", hi);
        end
        checks = checks + 1;
        if ({bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_err} !== {1'b1, 3'd1, 16'h0100, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL add_rsp: valid=%b op=%0d res=%h err=%b, want 1 1 0100 0",
                     bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_err);
        end
        exp_q.push_back(exp_t'({3'd1, 16'h0100, 1'b0}));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks = checks + 1;
        if (bus.rsp_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL add_single_rsp: rsp_valid=%b after pop, want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        int hi;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_cmd(3'd4, 8'h10, 8'h10, ok);
            alu_lat = 2;
            count_start(hi);
            checks = checks + 1;
            if (hi != 2) begin
                failures = failures + 1;
                $display("FAIL bp_start_len[%0d]: got %0d, want 2", k, hi);
            end
        end
        bus.cmd_op    = 3'd4;
        bus.cmd_a     = 8'h10;
        bus.cmd_b     = 8'h10;
        bus.cmd_valid = 1'b1;
        repeat (3) tick();
        checks = checks + 1;
        if ({bus.cmd_ready, bus.alu_start, bus.rsp_valid} !== 3'b001) begin
            failures = failures + 1;
            $display("FAIL bp_full_stall: cmd_ready=%b start=%b rsp_valid=%b, want 0 0 1",
                     bus.cmd_ready, bus.alu_start, bus.rsp_valid);
        end
        repeat (5) exp_q.push_back(exp_t'({3'd4, 16'h0100, 1'b0}));
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.cmd_valid = 1'b0;
        alu_lat = 2;
        checks = checks + 1;
        if (!seen || exp_q.size() > 4) begin
            failures = failures + 1;
            $display("FAIL bp_fifth_accept: ready_seen=%b pending=%0d, want 1 and <=4", seen, exp_q.size());
        end
        count_start(hi);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL bp_drain: %0d responses missing, want 0", exp_q.size());
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_pulse_ops();
        logic [2:0] ops [3];
        bit ok;
        ops = '{3'd0, 3'd5, 3'd6};
        for (int k = 0; k < 3; k++) begin
            send_cmd(ops[k], 8'(k + 1), 8'h5A, ok);
            checks = checks + 1;
            if ({bus.alu_start, bus.cmd_ready} !== 2'b10) begin
                failures = failures + 1;
                $display("FAIL pulse_on[%0d]: start=%b cmd_ready=%b, want 1 0", ops[k], bus.alu_start, bus.cmd_ready);
            end
            tick();
            checks = checks + 1;
            if ({bus.alu_start, bus.cmd_ready, bus.rsp_valid} !== 3'b010) begin
                failures = failures + 1;
                $display("FAIL pulse_off[%0d]: start=%b cmd_ready=%b rsp_valid=%b, want 0 1 0",
                         ops[k], bus.alu_start, bus.cmd_ready, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_reset_op();
        bit ok;
        send_cmd(3'd7, 8'h00, 8'h00, ok);
        for (int c = 0; c < 2; c++) begin
            checks = checks + 1;
            if ({bus.alu_reset_n, bus.alu_start} !== 2'b00) begin
                failures = failures + 1;
                $display("FAIL rstop_low[%0d]: alu_rst_n=%b start=%b, want 0 0", c, bus.alu_reset_n, bus.alu_start);
            end
            tick();
        end
        checks = checks + 1;
        if ({bus.alu_reset_n, bus.alu_start, bus.cmd_ready, bus.rsp_valid} !== 4'b1010) begin
            failures = failures + 1;
            $display("FAIL rstop_end: alu_rst_n=%b start=%b cmd_ready=%b rsp_valid=%b, want 1 0 1 0",
                     bus.alu_reset_n, bus.alu_start, bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        // Done in the last allowed cycle still completes normally.
        send_cmd(3'd4, 8'h12, 8'h34, ok);
        alu_lat = 16;
        count_start(hi);
        checks = checks + 1;
        if (hi != 16 || {bus.rsp_valid, bus.rsp_result, bus.rsp_err} !== {1'b1, 16'h03A8, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL late_done: cycles=%0d valid=%b res=%h err=%b, want 16 1 03a8 0",
                     hi, bus.rsp_valid, bus.rsp_result, bus.rsp_err);
        end
        exp_q.push_back(exp_t'({3'd4, 16'h03A8, 1'b0}));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        alu_en = 1'b0;
        send_cmd(3'd4, 8'h77, 8'h88, ok);
        count_start(hi);
        checks = checks + 1;
        if (hi != 16) begin
            failures = failures + 1;
            $display("FAIL timeout_len: got %0d cycles, want 16", hi);
        end
        checks = checks + 1;
        if ({bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_err, bus.alu_start} !== {1'b1, 3'd4, 16'h0000, 1'b1, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL timeout_rsp: valid=%b op=%0d res=%h err=%b start=%b, want 1 4 0000 1 0",
                     bus.rsp_valid, bus.rsp_op, bus.rsp_result, bus.rsp_err, bus.alu_start);
        end
        exp_q.push_back(exp_t'({3'd4, 16'h0000, 1'b1}));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        alu_en = 1'b1;
    endtask

    task automatic test_reset_abort();
        bit ok;
        int hi;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_cmd(3'd1, 8'(k), 8'h01, ok);
            alu_lat = 2;
            count_start(hi);
        end
        alu_en = 1'b0;
        send_cmd(3'd2, 8'hF0, 8'h3C, ok);
        repeat (3) tick();
        checks = checks + 1;
        if ({bus.alu_start, bus.rsp_valid} !== 2'b11) begin
            failures = failures + 1;
            $display("FAIL abort_setup: start=%b rsp_valid=%b, want 1 1", bus.alu_start, bus.rsp_valid);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks = checks + 1;
        if ({bus.rsp_valid, bus.alu_start, bus.cmd_ready} !== 3'b000) begin
            failures = failures + 1;
            $display("FAIL abort_flush: rsp_valid=%b start=%b cmd_ready=%b, want 0 0 0",
                     bus.rsp_valid, bus.alu_start, bus.cmd_ready);
        end
        tick();
        done_force = 1'b1;
        repeat (2) tick();
        checks = checks + 1;
        if ({bus.rsp_valid, bus.alu_start, bus.cmd_ready} !== 3'b001) begin
            failures = failures + 1;
            $display("FAIL abort_late_done: rsp_valid=%b start=%b cmd_ready=%b, want 0 0 1",
                     bus.rsp_valid, bus.alu_start, bus.cmd_ready);
        end
        done_force = 1'b0;
        alu_en     = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit ok;
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic [7:0] a;
            logic [7:0] b;
            int         lat;
            op            = 3'($urandom_range(0, 7));
            a             = 8'($urandom);
            b             = 8'($urandom);
            lat           = $urandom_range(1, 18);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            send_cmd(op, a, b, ok);
            if (ok) begin
                alu_lat = lat;
                if (is_wait(op)) begin
                    if (lat <= 16) exp_q.push_back(exp_t'({op, golden(op, a, b), 1'b0}));
                    else           exp_q.push_back(exp_t'({op, 16'h0000, 1'b1}));
                end
            end
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.rsp_valid !== 1'b0); i++) tick();
        checks = checks + 1;
        if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL random_drain: pending=%0d rsp_valid=%b, want 0 0", exp_q.size(), bus.rsp_valid);
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_pulse_ops();
        test_reset_op();
        test_timeout();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
